// File: rtl/pipe_drain_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_drain_buffer_pkg
// Purpose  : Shared sizing helpers and pointer arithmetic for the drain buffer.
// Revision : 1.0  initial release
// ============================================================================
package pipe_drain_buffer_pkg;

    localparam int c_DEF_BITWIDTH  = 8;
    localparam int c_DEF_NUM_STAGE = 2;
    localparam int c_DEF_DEPTH     = 4;

    // Counter width able to hold 0..depth inclusive (count and credits).
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry FIFO still needs a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Increment with wrap at depth-1, so depth need not be a power of two.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage : pipe_drain_buffer_pkg
`default_nettype wire

// File: rtl/pipe_drain_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : drain_fifo_core
// Purpose  : Circular result buffer with push/pop, occupancy and sticky
//            overflow detection for results arriving without a free slot.
// Revision : 1.0  initial release
// ============================================================================
module drain_fifo_core
    import pipe_drain_buffer_pkg::*;
#(
    parameter int BITWIDTH = c_DEF_BITWIDTH,
    parameter int DEPTH    = c_DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                pop,
    output logic                out_valid,
    output logic [BITWIDTH-1:0] out_data,
    output logic                overflow
);

    localparam int c_CNT_W = cnt_w(DEPTH);
    localparam int c_PTR_W = ptr_w(DEPTH);

    logic [BITWIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_count == c_CNT_W'(DEPTH));
    assign w_pop  = pop & out_valid;
    // A full buffer still accepts when the head leaves in the same cycle.
    assign w_push = in_valid & (~w_full | w_pop);

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= c_PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= c_PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            if (in_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign overflow  = r_overflow;

endmodule : drain_fifo_core
`default_nettype wire

// File: rtl/pipe_drain_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pipe_drain_buffer
// Purpose  : Credit-gated terminator turning a non-stallable pipeline tail
//            into a stallable valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module pipe_drain_buffer
    import pipe_drain_buffer_pkg::*;
#(
    parameter int BITWIDTH  = c_DEF_BITWIDTH,
    parameter int NUM_STAGE = c_DEF_NUM_STAGE,
    parameter int DEPTH     = c_DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic                     in_valid,
    input  logic [BITWIDTH-1:0]      in_data,
    output logic                     out_valid,
    output logic [BITWIDTH-1:0]      out_data,
    input  logic                     out_ready,
    output logic [cnt_w(DEPTH)-1:0]  credits,
    output logic                     overflow
);

    localparam int c_CNT_W = cnt_w(DEPTH);

    if (DEPTH < 1 || NUM_STAGE < 0) begin : g_param_check
        $error("pipe_drain_buffer: DEPTH must be >= 1 and NUM_STAGE >= 0");
    end

    logic [c_CNT_W-1:0] r_credits;
    logic               w_issue_fire;
    logic               w_out_fire;

    assign w_issue_fire = issue_valid & issue_ready;
    assign w_out_fire   = out_valid & out_ready;

    // One credit per slot; a slot freed by a pop is reusable next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= c_CNT_W'(DEPTH);
        end else if (w_issue_fire && !w_out_fire) begin
            r_credits <= r_credits - c_CNT_W'(1);
        end else if (!w_issue_fire && w_out_fire) begin
            r_credits <= r_credits + c_CNT_W'(1);
        end
    end

    assign issue_ready = (r_credits != '0);
    assign credits     = r_credits;

    drain_fifo_core #(
        .BITWIDTH (BITWIDTH),
        .DEPTH    (DEPTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .pop       (w_out_fire),
        .out_valid (out_valid),
        .out_data  (out_data),
        .overflow  (overflow)
    );

endmodule : pipe_drain_buffer
`default_nettype wire

// File: tb/tb_pipe_drain_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_drain_buffer
// Purpose  : Scoreboard bench with a 2-stage external pipeline delay model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_drain_buffer;

    localparam int BW = 8;
    localparam int NS = 2;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid = 1'b0;
    logic [BW-1:0] issue_data  = '0;
    logic          issue_ready;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic [2:0]    credits;
    logic          overflow;

    logic          force_v = 1'b0;
    logic [BW-1:0] force_d = '0;
    logic          ghost_v = 1'b0;
    logic [BW-1:0] ghost_d = '0;

    logic          pipe_v [NS];
    logic [BW-1:0] pipe_d [NS];

    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] last_pop = '0;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    pipe_drain_buffer #(
        .BITWIDTH  (BW),
        .NUM_STAGE (NS),
        .DEPTH     (DP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .credits     (credits),
        .overflow    (overflow)
    );

    // External pipeline; issued operands are also queued as expected results.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            if (issue_valid && issue_ready) exp_q.push_back(issue_data);
            pipe_v[0] <= (issue_valid && issue_ready) || ghost_v;
            pipe_d[0] <= ghost_v ? ghost_d : issue_data;
            for (int i = 1; i < NS; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign in_valid = pipe_v[NS-1] | force_v;
    assign in_data  = force_v ? force_d : pipe_d[NS-1];

    // Monitor: compares every accepted output against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard: got %0h expected nothing", out_data);
                end else begin
                    logic [BW-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL scoreboard: got %0h expected %0h", out_data, e);
                    end
                end
                last_pop = out_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue_burst(input logic [BW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            issue_valid = 1'b1;
            issue_data  = base + BW'(i);
            step();
        end
        issue_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        step();
        step();
        check("rst_credits", 32'(credits), 4);
        check("rst_issue_ready", 32'(issue_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_overflow", 32'(overflow), 0);
        rst = 1'b0;
        step();

        // Fill with downstream stalled
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1;
            issue_data  = 8'h11 * BW'(i + 1);
            step();
            check("fill_credits", 32'(credits), 32'(3 - i));
        end
        issue_valid = 1'b0;
        check("fill_issue_ready", 32'(issue_ready), 0);
        step();
        step();
        check("fill_count", 32'(dut.u_core.r_count), 4);
        check("fill_head", 32'(out_data), 32'h11);
        step();
        check("fill_head_stable", 32'(out_data), 32'h11);

        // Drain
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 32'(out_valid), 1);
            check("drain_data", 32'(out_data), 32'(8'h11 * (k + 1)));
            step();
            check("drain_credits", 32'(credits), 32'(k + 1));
        end
        check("drain_empty", 32'(out_valid), 0);

        // Streaming at full rate
        for (int i = 0; i < 20; i++) begin
            issue_valid = 1'b1;
            issue_data  = 8'h80 + BW'(i);
            check("stream_issue_ready", 32'(issue_ready), 1);
            step();
            if (i < 2) check("stream_latency", 32'(out_valid), 0);
            else begin
                check("stream_valid", 32'(out_valid), 1);
                check("stream_credits", 32'(credits), 1);
            end
        end
        issue_valid = 1'b0;
        repeat (5) step();
        check("stream_end_credits", 32'(credits), 4);
        check("stream_end_valid", 32'(out_valid), 0);

        // Overflow: uncredited result into a full buffer is dropped
        out_ready = 1'b0;
        issue_burst(8'hA1, 4);
        step();
        step();
        check("ovf_pre_count", 32'(dut.u_core.r_count), 4);
        check("ovf_pre_flag", 32'(overflow), 0);
        force_v = 1'b1;
        force_d = 8'h55;
        step();
        force_v = 1'b0;
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(dut.u_core.r_count), 4);
        check("ovf_head", 32'(out_data), 32'hA1);
        out_ready = 1'b1;
        repeat (5) step();
        check("ovf_sticky", 32'(overflow), 1);
        check("ovf_drained", 32'(out_valid), 0);
        check("ovf_last", 32'(last_pop), 32'hA4);

        // Asynchronous reset with results buffered and in flight
        out_ready = 1'b0;
        issue_burst(8'hB1, 3);
        step();
        step();
        issue_valid = 1'b1;
        issue_data  = 8'hB4;
        step();
        issue_valid = 1'b0;
        ghost_v     = 1'b1;
        ghost_d     = 8'hB5;
        step();
        ghost_v = 1'b0;
        check("mid_count", 32'(dut.u_core.r_count), 3);
        check("mid_credits", 32'(credits), 0);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_credits", 32'(credits), 4);
        check("arst_issue_ready", 32'(issue_ready), 1);
        check("arst_overflow", 32'(overflow), 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        issue_valid = 1'b1;
        issue_data  = 8'h66;
        step();
        issue_valid = 1'b0;
        check("post_rst_lat1", 32'(out_valid), 0);
        step();
        check("post_rst_lat2", 32'(out_valid), 0);
        step();
        check("post_rst_valid", 32'(out_valid), 1);
        check("post_rst_data", 32'(out_data), 32'h66);
        out_ready = 1'b1;
        step();
        check("post_rst_empty", 32'(out_valid), 0);

        // Push and pop together at full
        out_ready = 1'b0;
        issue_burst(8'hC1, 4);
        step();
        step();
        check("pp_pre_count", 32'(dut.u_core.r_count), 4);
        out_ready = 1'b1;
        force_v   = 1'b1;
        force_d   = 8'h77;
        exp_q.push_back(8'h77);
        step();
        force_v = 1'b0;
        check("pp_overflow", 32'(overflow), 0);
        check("pp_count", 32'(dut.u_core.r_count), 4);
        check("pp_head", 32'(out_data), 32'hC2);
        repeat (5) step();
        check("pp_empty", 32'(out_valid), 0);
        check("pp_last", 32'(last_pop), 32'h77);
        check("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_drain_buffer
`default_nettype wire
